multicore_sched: RTL and testbench
==================================

Name: multicore_sched

Overview:
- Parametrised scheduler/collector for an array of NCORES ssf cores sharing one io_in stream.
- Releases core resets one at a time at a programmable stagger after a start command, so the cores process time-offset windows.
- Merges the cores' output buses into one registered stream, using fixed-priority or round-robin arbitration, and counts collisions.
- Sits between the top level and the ssf instances; the ssf cores themselves are instantiated outside this block.

Parameters:
NCORES, 25, number of cores controlled (2..64)
DW, 32, signed data width of each core output
STAGGER, 1320, clock cycles between consecutive core releases (>=1)
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
IW, $clog2(NCORES), width of core index fields

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; starts the release sequence when in IDLE
abort  in  1  synchronous; puts every core back into reset
core_rst  out  NCORES  per-core active-high reset; bit k drives core k
core_out  in  NCORES*DW  packed core outputs; core k occupies bits [k*DW +: DW]
core_en  in  2*NCORES  packed 2-bit out_en per core; 2'b01 = valid word
io_out  out  DW  merged signed output word
out_en  out  2  merged output enable; 2'b01 when io_out is valid
out_idx  out  IW  index of the core that supplied io_out
collision  out  1  more than one core was valid in the sampled cycle
coll_cnt  out  16  saturating count of collision cycles
busy  out  1  high while in RELEASE
all_run  out  1  high in RUN (every core released)

Behaviour:
- Reset (rst=0, asynchronous):
  - core_rst = all ones; state = IDLE; core pointer k = 0; stagger counter cnt = 0.
  - io_out = 0; out_en = 0; out_idx = 0; collision = 0; coll_cnt = 0.
  - Round-robin pointer = NCORES-1, so core 0 has first priority.
- FSM states: IDLE, RELEASE, RUN.
  - IDLE, start=1 -> RELEASE. core_rst[0] clears on that same clock edge. k = 0, cnt = 0.
  - RELEASE:
    - cnt increments every cycle.
    - When cnt == STAGGER-1 and k < NCORES-1: k <= k+1, cnt <= 0, core_rst[k+1] <= 0.
    - When cnt == STAGGER-1 and k == NCORES-1: go to RUN.
    - Result: core j is released exactly j*STAGGER cycles after core 0.
    - Once cleared, a core_rst bit stays 0 until abort or rst.
  - RUN: hold; all_run = 1.
  - start is ignored outside IDLE.
  - abort=1 in any state -> IDLE at the next edge: core_rst = all ones, k = 0, cnt = 0.
  - abort has priority over start in the same cycle.
- busy = (state == RELEASE); all_run = (state == RUN). Both are registered state decodes.
- Arbitration, every cycle:
  - Candidate set: cores with core_en[k] == 2'b01 and core_rst[k] == 0. Encodings 2'b00, 2'b10 and 2'b11 are not candidates.
  - ARB_MODE=0: grant the lowest-index candidate.
  - ARB_MODE=1: grant the first candidate strictly after the RR pointer, wrapping NCORES-1 -> 0. The pointer updates to the granted index; it is unchanged when no core is granted.
  - With a grant, next edge: io_out = core_out[g], out_en = 2'b01, out_idx = g.
  - With no grant, next edge: io_out = 0, out_en = 2'b00, out_idx holds its previous value.
  - Latency: exactly 1 cycle from core inputs to merged outputs.
  - Words from non-granted cores are dropped, not buffered.
- collision is registered alongside the grant and is high when the candidate count is >= 2.
- coll_cnt increments on each collision cycle and saturates at 16'hFFFF. Only rst clears it; abort does not.
- Arithmetic: io_out is passed through unmodified as signed DW bits. cnt is $clog2(STAGGER+1) bits wide.

Test Plan:
- Release timing (NCORES=4, STAGGER=5): pulse start at cycle 10 -> core_rst[0..3] fall at edges 10, 15, 20, 25. all_run rises at edge 30; busy is high over edges 10..29.
- Abort mid-RELEASE (NCORES=4, STAGGER=5): abort at cycle 17 -> at edge 17 core_rst = 4'b1111 and state = IDLE. A new start at 20 -> core 0 released at edge 20 and core 1 at edge 25.
- Fixed priority (ARB_MODE=0), all cores released: core_en = 01 on cores 2 and 5 with data -7 and 100 -> next cycle io_out = -7, out_idx = 2, collision = 1, coll_cnt +1.
- Round robin (ARB_MODE=1): cores 1 and 3 both valid for 4 cycles -> out_idx sequence 1, 3, 1, 3. coll_cnt increases by 4.
- Gating: core 3 still in reset but driving core_en = 01 -> out_en = 00. core_en = 2'b11 on a released core -> out_en = 00.
- Async reset: drop rst in RUN at mid-cycle -> all outputs and core_rst return to reset values immediately, without a clock edge. Force 65540 collision cycles -> coll_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/multicore_sched.sv
// Staggered reset release for an array of cores plus a one-cycle merge of their output
// buses, using fixed-priority or round-robin arbitration, with a saturating collision counter.
module multicore_sched #(
    parameter int unsigned NCORES   = 25,
    parameter int unsigned DW       = 32,
    parameter int unsigned STAGGER  = 1320,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned IW       = $clog2(NCORES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic [NCORES-1:0]          core_rst_o,
    input  logic [NCORES*DW-1:0]       core_out_i,
    input  logic [2*NCORES-1:0]        core_en_i,
    output logic signed [DW-1:0]       io_out_o,
    output logic [1:0]                 out_en_o,
    output logic [IW-1:0]              out_idx_o,
    output logic                       collision_o,
    output logic [15:0]                coll_cnt_o,
    output logic                       busy_o,
    output logic                       all_run_o
);

    localparam int unsigned CW = $clog2(STAGGER + 1);

    typedef enum logic [1:0] {StIdle, StRelease, StRun} state_e;

    state_e            state_q;
    logic [NCORES-1:0] core_rst_q;
    logic [IW-1:0]     k_q;
    logic [IW-1:0]     k_nxt;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              all_run_q;

    assign k_nxt = k_q + IW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            core_rst_q <= '1;
            k_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            all_run_q  <= 1'b0;
        end else if (abort_i) begin
            state_q    <= StIdle;
            core_rst_q <= '1;
            k_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            all_run_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q       <= StRelease;
                        core_rst_q[0] <= 1'b0;
                        k_q           <= '0;
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                    end
                end
                StRelease: begin
                    if (cnt_q == CW'(STAGGER - 1)) begin
                        cnt_q <= '0;
                        // The last stagger period after the final release ends the sequence.
                        if (k_q == IW'(NCORES - 1)) begin
                            state_q   <= StRun;
                            busy_q    <= 1'b0;
                            all_run_q <= 1'b1;
                        end else begin
                            k_q               <= k_nxt;
                            core_rst_q[k_nxt] <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StRun: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [NCORES-1:0]    cand;
    logic                 multi;
    logic                 lo_vld;
    logic [IW-1:0]        lo_idx;
    logic                 hi_vld;
    logic [IW-1:0]        hi_idx;
    logic                 gnt_vld;
    logic [IW-1:0]        gnt_idx;
    logic [DW-1:0]        gnt_data;
    logic [IW-1:0]        rr_ptr_q;
    logic signed [DW-1:0] io_out_q;
    logic [1:0]           out_en_q;
    logic [IW-1:0]        out_idx_q;
    logic                 collision_q;
    logic [15:0]          coll_cnt_q;

    // lo_* is the lowest candidate overall, hi_* the lowest candidate above the RR pointer.
    always_comb begin
        cand   = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        hi_vld = 1'b0;
        hi_idx = '0;
        for (int j = 0; j < NCORES; j++) begin
            cand[j] = (core_en_i[2*j +: 2] == 2'b01) && !core_rst_q[j];
        end
        for (int j = NCORES - 1; j >= 0; j--) begin
            if (cand[j]) begin
                lo_vld = 1'b1;
                lo_idx = IW'(j);
                if (IW'(j) > rr_ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = IW'(j);
                end
            end
        end
        gnt_vld = lo_vld;
        gnt_idx = (ARB_MODE == 1 && hi_vld) ? hi_idx : lo_idx;
        gnt_data = '0;
        for (int j = 0; j < NCORES; j++) begin
            if (IW'(j) == gnt_idx) gnt_data = core_out_i[j*DW +: DW];
        end
    end

    assign multi = |(cand & (cand - NCORES'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= IW'(NCORES - 1);
            io_out_q    <= '0;
            out_en_q    <= 2'b00;
            out_idx_q   <= '0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            collision_q <= multi;
            if (multi && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
            if (gnt_vld) begin
                io_out_q  <= gnt_data;
                out_en_q  <= 2'b01;
                out_idx_q <= gnt_idx;
                rr_ptr_q  <= gnt_idx;
            end else begin
                io_out_q <= '0;
                out_en_q <= 2'b00;
            end
        end
    end

    assign core_rst_o  = core_rst_q;
    assign io_out_o    = io_out_q;
    assign out_en_o    = out_en_q;
    assign out_idx_o   = out_idx_q;
    assign collision_o = collision_q;
    assign coll_cnt_o  = coll_cnt_q;
    assign busy_o      = busy_q;
    assign all_run_o   = all_run_q;

endmodule

// File: tb/tb_multicore_sched.sv
// Bench for multicore_sched: a fixed-priority and a round-robin instance share stimulus and
// are compared against a cycle-level behavioural model of release timing and arbitration.
module tb_multicore_sched;

    localparam int NC   = 8;
    localparam int DW   = 16;
    localparam int STAG = 5;
    localparam int IW   = $clog2(NC);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 start;
    logic                 abort;
    logic [NC*DW-1:0]     core_out;
    logic [2*NC-1:0]      core_en;
    logic [NC-1:0]        rst_w[2];
    logic signed [DW-1:0] io_w[2];
    logic [1:0]           en_w[2];
    logic [IW-1:0]        idx_w[2];
    logic                 coll_w[2];
    logic [15:0]          cnt_w[2];
    logic                 busy_w[2];
    logic                 run_w[2];

    multicore_sched #(.NCORES(NC), .DW(DW), .STAGGER(STAG), .ARB_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .core_rst_o(rst_w[0]), .core_out_i(core_out), .core_en_i(core_en),
        .io_out_o(io_w[0]), .out_en_o(en_w[0]), .out_idx_o(idx_w[0]),
        .collision_o(coll_w[0]), .coll_cnt_o(cnt_w[0]), .busy_o(busy_w[0]),
        .all_run_o(run_w[0])
    );

    multicore_sched #(.NCORES(NC), .DW(DW), .STAGGER(STAG), .ARB_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .core_rst_o(rst_w[1]), .core_out_i(core_out), .core_en_i(core_en),
        .io_out_o(io_w[1]), .out_en_o(en_w[1]), .out_idx_o(idx_w[1]),
        .collision_o(coll_w[1]), .coll_cnt_o(cnt_w[1]), .busy_o(busy_w[1]),
        .all_run_o(run_w[1])
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0/1/2 = idle/release/run, t = edges since start.
    int                   m_phase;
    int                   m_t;
    logic [NC-1:0]        m_rst;
    int                   rr_ptr;
    logic signed [DW-1:0] e_io[2];
    logic [1:0]           e_en[2];
    int                   e_idx[2];
    logic                 e_coll;
    int                   e_cnt;

    task automatic reset_model();
        m_phase = 0;
        m_t     = 0;
        m_rst   = '1;
        rr_ptr  = NC - 1;
        e_coll  = 1'b0;
        e_cnt   = 0;
        for (int m = 0; m < 2; m++) begin
            e_io[m]  = '0;
            e_en[m]  = 2'b00;
            e_idx[m] = 0;
        end
    endtask

    function automatic bit is_cand(int k);
        return core_en[2*k +: 2] == 2'b01 && m_rst[k] == 1'b0;
    endfunction

    task automatic tick();
        int c[$];
        int g[2];
        for (int k = 0; k < NC; k++) if (is_cand(k)) c.push_back(k);
        g[0] = (c.size() > 0) ? c[0] : -1;
        g[1] = -1;
        for (int s = 1; s <= NC && g[1] < 0; s++) begin
            if (is_cand((rr_ptr + s) % NC)) g[1] = (rr_ptr + s) % NC;
        end
        for (int m = 0; m < 2; m++) begin
            if (g[m] >= 0) begin
                e_io[m]  = core_out[g[m]*DW +: DW];
                e_en[m]  = 2'b01;
                e_idx[m] = g[m];
            end else begin
                e_io[m] = '0;
                e_en[m] = 2'b00;
            end
        end
        if (g[1] >= 0) rr_ptr = g[1];
        e_coll = (c.size() >= 2);
        if (e_coll && e_cnt < 65535) e_cnt++;
        if (abort) begin
            m_phase = 0;
            m_rst   = '1;
        end else if (m_phase == 0 && start) begin
            m_phase  = 1;
            m_t      = 0;
            m_rst[0] = 1'b0;
        end else if (m_phase == 1) begin
            m_t++;
            if (m_t % STAG == 0 && m_t / STAG < NC) m_rst[m_t / STAG] = 1'b0;
            if (m_t == NC * STAG) m_phase = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(int k, logic [1:0] en, logic [DW-1:0] d);
        core_en[2*k +: 2]   = en;
        core_out[k*DW +: DW] = d;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic get_to_run();
        do_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NC * STAG) tick();
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rst_w[m] !== '1 || io_w[m] !== '0 || en_w[m] !== 2'b00 || idx_w[m] !== '0 ||
                coll_w[m] !== 1'b0 || cnt_w[m] !== 16'h0 || busy_w[m] !== 1'b0 ||
                run_w[m] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: got rst=%h io=%h en=%b idx=%0d coll=%b cnt=%h busy=%b run=%b want all-ones/zeros",
                         m, rst_w[m], io_w[m], en_w[m], idx_w[m], coll_w[m], cnt_w[m],
                         busy_w[m], run_w[m]);
            end
        end
    endtask

    task automatic test_release();
        logic [NC-1:0] first_rel;
        first_rel = {{(NC-1){1'b1}}, 1'b0};
        do_abort();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rst_w[0] !== first_rel) begin
            errors++;
            $display("FAIL release_first: got %b want %b", rst_w[0], first_rel);
        end
        for (int n = 0; n < NC * STAG + 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (rst_w[m] !== m_rst || busy_w[m] !== (m_phase == 1) ||
                    run_w[m] !== (m_phase == 2)) begin
                    errors++;
                    $display("FAIL release dut%0d t=%0d: got rst=%b busy=%b run=%b want rst=%b busy=%b run=%b",
                             m, n, rst_w[m], busy_w[m], run_w[m], m_rst, m_phase == 1,
                             m_phase == 2);
                end
            end
            tick();
        end
        checks++;
        if (run_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rst_w[0] !== '0) begin
            errors++;
            $display("FAIL release_done: got run=%b busy=%b rst=%b want 1 0 0",
                     run_w[0], busy_w[0], rst_w[0]);
        end
    endtask

    task automatic test_abort();
        logic [NC-1:0] r0;
        logic [NC-1:0] r1;
        r0 = {{(NC-1){1'b1}}, 1'b0};
        r1 = {{(NC-2){1'b1}}, 2'b00};
        do_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (rst_w[0] !== '1 || busy_w[0] !== 1'b0 || rst_w[1] !== m_rst) begin
            errors++;
            $display("FAIL abort: got rst=%b busy=%b want rst=all-ones busy=0", rst_w[0], busy_w[0]);
        end
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (rst_w[0] !== r0 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_core0: got rst=%b busy=%b want %b 1", rst_w[0], busy_w[0], r0);
        end
        repeat (4) tick();
        checks++;
        if (rst_w[0] !== r0) begin
            errors++;
            $display("FAIL restart_hold: got %b want %b", rst_w[0], r0);
        end
        tick();
        checks++;
        if (rst_w[0] !== r1) begin
            errors++;
            $display("FAIL restart_core1: got %b want %b", rst_w[0], r1);
        end
    endtask

    task automatic test_fixed_prio();
        int c0;
        get_to_run();
        core_en = '0;
        set_core(2, 2'b01, DW'(-7));
        set_core(5, 2'b01, DW'(100));
        c0 = int'(cnt_w[0]);
        tick();
        checks++;
        if (io_w[0] !== -16'sd7 || idx_w[0] !== IW'(2) || en_w[0] !== 2'b01 ||
            coll_w[0] !== 1'b1 || int'(cnt_w[0]) != c0 + 1) begin
            errors++;
            $display("FAIL fixed_prio: got io=%0d idx=%0d en=%b coll=%b cnt=%0d want -7 2 01 1 %0d",
                     io_w[0], idx_w[0], en_w[0], coll_w[0], cnt_w[0], c0 + 1);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (io_w[m] !== e_io[m] || idx_w[m] !== IW'(e_idx[m]) || int'(cnt_w[m]) != e_cnt) begin
                errors++;
                $display("FAIL fixed_prio_model dut%0d: got io=%0d idx=%0d cnt=%0d want %0d %0d %0d",
                         m, io_w[m], idx_w[m], cnt_w[m], e_io[m], e_idx[m], e_cnt);
            end
        end
        core_en = '0;
    endtask

    task automatic test_round_robin();
        int exp_seq[4] = '{1, 3, 1, 3};
        int c0;
        core_en = '0;
        set_core(0, 2'b01, DW'(11));
        tick();
        core_en = '0;
        set_core(1, 2'b01, DW'(1111));
        set_core(3, 2'b01, DW'(3333));
        c0 = int'(cnt_w[1]);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (idx_w[1] !== IW'(exp_seq[i]) || en_w[1] !== 2'b01 || idx_w[0] !== IW'(1)) begin
                errors++;
                $display("FAIL round_robin step %0d: got rr_idx=%0d en=%b fp_idx=%0d want %0d 01 1",
                         i, idx_w[1], en_w[1], idx_w[0], exp_seq[i]);
            end
        end
        checks++;
        if (int'(cnt_w[1]) != c0 + 4 || io_w[1] !== e_io[1]) begin
            errors++;
            $display("FAIL round_robin_cnt: got cnt=%0d io=%0d want %0d %0d",
                     cnt_w[1], io_w[1], c0 + 4, e_io[1]);
        end
        core_en = '0;
    endtask

    task automatic test_gating();
        logic [1:0] pat_en[4] = '{2'b01, 2'b11, 2'b10, 2'b01};
        int         pat_k[4]  = '{3, 0, 0, 0};
        logic [1:0] want[4]   = '{2'b00, 2'b00, 2'b00, 2'b01};
        do_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            core_en = '0;
            set_core(pat_k[i], pat_en[i], DW'(16'h5A00 + i));
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (en_w[m] !== want[i]) begin
                    errors++;
                    $display("FAIL gating case %0d dut%0d: got out_en=%b want %b",
                             i, m, en_w[m], want[i]);
                end
            end
        end
        core_en = '0;
    endtask

    task automatic test_random();
        do_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NC; k++) begin
                set_core(k, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b01, DW'($urandom));
            end
            abort = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 9) == 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (io_w[m] !== e_io[m] || en_w[m] !== e_en[m] || idx_w[m] !== IW'(e_idx[m]) ||
                    coll_w[m] !== e_coll || int'(cnt_w[m]) != e_cnt || rst_w[m] !== m_rst ||
                    busy_w[m] !== (m_phase == 1) || run_w[m] !== (m_phase == 2)) begin
                    errors++;
                    $display("FAIL random dut%0d n=%0d: got io=%h en=%b idx=%0d coll=%b cnt=%0d rst=%b busy=%b run=%b want io=%h en=%b idx=%0d coll=%b cnt=%0d rst=%b busy=%b run=%b",
                             m, n, io_w[m], en_w[m], idx_w[m], coll_w[m], cnt_w[m], rst_w[m],
                             busy_w[m], run_w[m], e_io[m], e_en[m], e_idx[m], e_coll, e_cnt,
                             m_rst, m_phase == 1, m_phase == 2);
                end
            end
        end
        abort   = 1'b0;
        start   = 1'b0;
        core_en = '0;
    endtask

    task automatic test_async_reset();
        get_to_run();
        set_core(1, 2'b01, DW'(77));
        set_core(2, 2'b01, DW'(88));
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (rst_w[m] !== '1 || io_w[m] !== '0 || en_w[m] !== 2'b00 || idx_w[m] !== '0 ||
                coll_w[m] !== 1'b0 || cnt_w[m] !== 16'h0 || busy_w[m] !== 1'b0 ||
                run_w[m] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: got rst=%b io=%h en=%b idx=%0d coll=%b cnt=%h busy=%b run=%b want reset values",
                         m, rst_w[m], io_w[m], en_w[m], idx_w[m], coll_w[m], cnt_w[m],
                         busy_w[m], run_w[m]);
            end
        end
        #1;
        rst_n = 1'b1;
        reset_model();
        core_en = '0;
    endtask

    task automatic test_saturation();
        get_to_run();
        set_core(0, 2'b01, DW'(1));
        set_core(1, 2'b01, DW'(2));
        repeat (65540) tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (cnt_w[m] !== 16'hFFFF || coll_w[m] !== 1'b1 || int'(cnt_w[m]) != e_cnt) begin
                errors++;
                $display("FAIL saturation dut%0d: got cnt=%h coll=%b want FFFF 1 (model %0d)",
                         m, cnt_w[m], coll_w[m], e_cnt);
            end
        end
        core_en = '0;
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        core_en  = '0;
        core_out = '0;
        reset_model();
        #1 rst_n = 1'b0;
        #3;
        test_reset();
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_release();
        test_abort();
        test_fixed_prio();
        test_round_robin();
        test_gating();
        test_random();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
